// File: rtl/remote_comm_if.sv
// Host-side bus of the remote command link: command request, completion and response byte.
// send_cmd is a request sampled every cycle; it is taken only when busy=0 and cmd_sent=0, ignored otherwise.
interface remote_comm_if;
    logic [15:0] cmd;
    logic        send_cmd;
    logic        busy;
    logic        cmd_sent;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        clr_resp_rdy;
    logic [1:0]  tx_state;
    logic [1:0]  rx_state;

    modport master (
        output cmd, send_cmd, clr_resp_rdy,
        input  busy, cmd_sent, resp, resp_rdy, tx_state, rx_state
    );

    modport slave (
        input  cmd, send_cmd, clr_resp_rdy,
        output busy, cmd_sent, resp, resp_rdy, tx_state, rx_state
    );
endinterface

// File: rtl/remote_comm.sv
// Remote controller UART link: sends a 16-bit command as two bytes (high first)
// and receives 8-bit responses from the robot.
module remote_comm #(
    parameter int BAUD_DIV = 5208
) (
    input  logic         clk,
    input  logic         rst,
    remote_comm_if.slave bus,
    output logic         TX,
    input  logic         RX
);
    localparam int CW = $clog2(BAUD_DIV + 1);

    typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t     tx_state;
    logic [15:0]   hold;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic          tx_reg;
    logic          busy_r;
    logic          sent_r;
    logic [7:0]    cur_byte;
    logic          accept;

    rx_state_t     rx_state;
    logic [1:0]    rx_sync;
    logic          rx_s;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    shreg;
    logic [7:0]    resp_r;
    logic          rdy_r;

    // Frame bit index 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
    function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
        logic [2:0] sel;
        sel = 3'(idx - 4'd1);
        if (idx == 4'd0)
            return 1'b0;
        else if (idx >= 4'd9)
            return 1'b1;
        else
            return data[sel];
    endfunction

    assign cur_byte = (tx_state == TX_HIGH) ? hold[15:8] : hold[7:0];
    // The cmd_sent cycle blocks acceptance so back-to-back requests get a one-cycle gap.
    assign accept   = (tx_state == TX_IDLE) && bus.send_cmd && !sent_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            hold     <= '0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_reg   <= 1'b1;
            busy_r   <= 1'b0;
            sent_r   <= 1'b0;
        end else begin
            sent_r <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (accept) begin
                        hold     <= bus.cmd;
                        tx_state <= TX_HIGH;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_reg   <= 1'b0;
                        busy_r   <= 1'b1;
                    end
                end
                TX_HIGH, TX_LOW: begin
                    if (tx_cnt == CW'(BAUD_DIV - 1)) begin
                        tx_cnt <= '0;
                        if (tx_bit == 4'd9) begin
                            tx_bit <= '0;
                            if (tx_state == TX_HIGH) begin
                                // Low byte start bit follows the high stop bit with no idle gap.
                                tx_state <= TX_LOW;
                                tx_reg   <= 1'b0;
                            end else begin
                                tx_state <= TX_IDLE;
                                tx_reg   <= 1'b1;
                                busy_r   <= 1'b0;
                                sent_r   <= 1'b1;
                            end
                        end else begin
                            tx_bit <= tx_bit + 4'd1;
                            tx_reg <= frame_bit(cur_byte, tx_bit + 4'd1);
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx_reg   <= 1'b1;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], RX};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            shreg    <= '0;
            resp_r   <= '0;
            rdy_r    <= 1'b0;
        end else begin
            // Clear first so a same-cycle set below takes priority.
            if (bus.clr_resp_rdy || accept)
                rdy_r <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        rx_state <= RX_START;
                        rx_cnt   <= CW'(BAUD_DIV / 2);
                    end
                end
                RX_START: begin
                    if (rx_cnt == CW'(1)) begin
                        if (rx_s) begin
                            rx_state <= RX_IDLE;
                            rx_cnt   <= '0;
                        end else begin
                            rx_state <= RX_DATA;
                            rx_cnt   <= CW'(BAUD_DIV);
                            rx_bit   <= '0;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == CW'(1)) begin
                        shreg  <= {rx_s, shreg[7:1]};
                        rx_cnt <= CW'(BAUD_DIV);
                        if (rx_bit == 3'd7)
                            rx_state <= RX_STOP;
                        else
                            rx_bit <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == CW'(1)) begin
                        // A low stop bit is a framing error: the byte is dropped silently.
                        if (rx_s) begin
                            resp_r <= shreg;
                            rdy_r  <= 1'b1;
                        end
                        rx_state <= RX_IDLE;
                        rx_cnt   <= '0;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                    rx_cnt   <= '0;
                end
            endcase
        end
    end

    assign TX           = tx_reg;
    assign bus.busy     = busy_r;
    assign bus.cmd_sent = sent_r;
    assign bus.resp     = resp_r;
    assign bus.resp_rdy = rdy_r;
    assign bus.tx_state = tx_state;
    assign bus.rx_state = rx_state;
endmodule
